plic_claim_engine: RTL and testbench

- Hardware initiator for the PLIC claim/complete protocol of one context. Sits between the PLIC MMIO register port and an on-chip interrupt consumer, such as a DMA or accelerator sequencer that services device interrupts without the CPU.
- On external-interrupt-pending, it reads the context's claim register, hands the ID to the consumer over valid/ready, and waits for the consumer's completion.
- It then writes the ID back to the claim/complete register.
- It shares the PLIC MMIO port with the CPU through a req/gnt arbiter.

---
 rtl/plic_pkg.sv | 24 ++
 rtl/plic_claim_engine_if.sv | 42 ++++
 rtl/plic_claim_engine.sv | 131 +++++++++++++
 tb/tb_plic_claim_engine.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plic_pkg.sv
// PLIC register map constants and claim engine state encoding.
// Shared by the claim engine and the CPU-side driver model.
package plic_pkg;

    localparam logic [29:0] PLIC_CLAIM_BASE = 30'h200004;
    localparam logic [29:0] PLIC_CTX_STRIDE = 30'h1000;
    localparam int          PLIC_ID_NONE    = 0;

    typedef enum logic [2:0] {
        IDLE,
        CLAIM_REQ,
        CLAIM_WAIT,
        PRESENT,
        WAIT_CMPL,
        CMPL_REQ,
        HOLD
    } plic_state_e;

    // Byte offset of the claim/complete register of one context.
    function automatic logic [29:0] claim_offset(input int ctx);
        return PLIC_CLAIM_BASE + PLIC_CTX_STRIDE * 30'(ctx);
    endfunction

endpackage

// File: rtl/plic_claim_engine_if.sv
// MMIO bus, consumer handshake and status bundle of the claim engine.
// master = engine side, slave = PLIC/arbiter/consumer side.
interface plic_claim_engine_if #(
    parameter int W_ID  = 6,
    parameter int W_CNT = 16
);
    logic              i_enable;
    logic              i_eip;
    logic              o_req;
    logic              i_gnt;
    logic [29:0]       o_offset;
    logic              o_we;
    logic              o_re;
    logic [31:0]       o_wdata;
    logic [31:0]       i_rdata;
    logic              o_id_valid;
    logic [W_ID-1:0]   o_id;
    logic              i_id_ready;
    logic              i_cmpl_valid;
    logic [W_ID-1:0]   i_cmpl_id;
    logic              o_cmpl_ready;
    logic              o_busy;
    logic [W_CNT-1:0]  o_spurious_cnt;
    logic              o_cmpl_err;

    modport master (
        input  i_enable, i_eip, i_gnt, i_rdata,
        input  i_id_ready, i_cmpl_valid, i_cmpl_id,
        output o_req, o_offset, o_we, o_re, o_wdata,
        output o_id_valid, o_id, o_cmpl_ready,
        output o_busy, o_spurious_cnt, o_cmpl_err
    );

    modport slave (
        output i_enable, i_eip, i_gnt, i_rdata,
        output i_id_ready, i_cmpl_valid, i_cmpl_id,
        input  o_req, o_offset, o_we, o_re, o_wdata,
        input  o_id_valid, o_id, o_cmpl_ready,
        input  o_busy, o_spurious_cnt, o_cmpl_err
    );

endinterface

// File: rtl/plic_claim_engine.sv
// Hardware PLIC claim/complete initiator for one context.
// Claims on EIP, hands the ID to a consumer, writes it back on completion.
module plic_claim_engine
    import plic_pkg::*;
#(
    parameter int CTX     = 0,
    parameter int W_ID    = 6,
    parameter int HOLDOFF = 3,
    parameter int W_CNT   = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    plic_claim_engine_if.master  bus
);

    localparam int W_HO = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [W_HO-1:0] HO_LOAD   = W_HO'(HOLDOFF - 1);
    localparam logic [29:0]     CLAIM_OFF = claim_offset(CTX);

    plic_state_e       state_q, state_d;
    logic [W_ID-1:0]   id_q, id_d;
    logic [W_HO-1:0]   ho_q, ho_d;
    logic [W_CNT-1:0]  spur_q, spur_d;
    logic              err_q, err_d;
    logic              req_q, req_d;
    logic              id_valid_q, id_valid_d;
    logic              cmpl_ready_q, cmpl_ready_d;
    logic              busy_q, busy_d;

    logic [W_ID-1:0]   rd_id;
    logic              re;
    logic              we;
    logic              unused_rdata;

    // Only the low W_ID bits of the claim register carry the ID.
    assign rd_id        = bus.i_rdata[W_ID-1:0];
    assign unused_rdata = ^bus.i_rdata;

    // Next-state, latched ID, holdoff timer, counters and registered outputs.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        ho_d    = ho_q;
        spur_d  = spur_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.i_enable && bus.i_eip) state_d = CLAIM_REQ;
            end
            CLAIM_REQ: begin
                if (bus.i_gnt) state_d = CLAIM_WAIT;
            end
            CLAIM_WAIT: begin
                if (rd_id == W_ID'(PLIC_ID_NONE)) begin
                    if (spur_q != '1) spur_d = spur_q + W_CNT'(1);
                    ho_d    = HO_LOAD;
                    state_d = HOLD;
                end else begin
                    id_d    = rd_id;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.i_id_ready) state_d = WAIT_CMPL;
            end
            WAIT_CMPL: begin
                if (bus.i_cmpl_valid) begin
                    if (bus.i_cmpl_id != id_q) err_d = 1'b1;
                    state_d = CMPL_REQ;
                end
            end
            CMPL_REQ: begin
                if (bus.i_gnt) begin
                    ho_d    = HO_LOAD;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (ho_q == '0) state_d = IDLE;
                else            ho_d    = ho_q - W_HO'(1);
            end
            default: state_d = IDLE;
        endcase
        req_d        = (state_d == CLAIM_REQ) || (state_d == CMPL_REQ);
        id_valid_d   = (state_d == PRESENT);
        cmpl_ready_d = (state_d == WAIT_CMPL);
        busy_d       = (state_d != IDLE);
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            id_q         <= '0;
            ho_q         <= '0;
            spur_q       <= '0;
            err_q        <= 1'b0;
            req_q        <= 1'b0;
            id_valid_q   <= 1'b0;
            cmpl_ready_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            ho_q         <= ho_d;
            spur_q       <= spur_d;
            err_q        <= err_d;
            req_q        <= req_d;
            id_valid_q   <= id_valid_d;
            cmpl_ready_q <= cmpl_ready_d;
            busy_q       <= busy_d;
        end
    end

    // Strobes fire only in the granted cycle; address/data are quiet otherwise.
    assign re = (state_q == CLAIM_REQ) && bus.i_gnt;
    assign we = (state_q == CMPL_REQ) && bus.i_gnt;

    assign bus.o_re           = re;
    assign bus.o_we           = we;
    assign bus.o_offset       = (re || we) ? CLAIM_OFF : '0;
    assign bus.o_wdata        = we ? 32'(id_q) : '0;
    assign bus.o_req          = req_q;
    assign bus.o_id_valid     = id_valid_q;
    assign bus.o_id           = id_valid_q ? id_q : '0;
    assign bus.o_cmpl_ready   = cmpl_ready_q;
    assign bus.o_busy         = busy_q;
    assign bus.o_spurious_cnt = spur_q;
    assign bus.o_cmpl_err     = err_q;

endmodule

// File: tb/tb_plic_claim_engine.sv
// Bench for plic_claim_engine: PLIC model, consumer driver, scoreboard.
// Second instance with a 2-bit counter exercises saturation.
module tb_plic_claim_engine;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    plic_claim_engine_if #(.W_ID(6), .W_CNT(16)) ifc ();
    plic_claim_engine_if #(.W_ID(6), .W_CNT(2))  ifc2 ();

    plic_claim_engine #(
        .CTX(0), .W_ID(6), .HOLDOFF(3), .W_CNT(16)
    ) dut (
        .CLK(CLK), .RST(RST), .bus(ifc.master)
    );

    plic_claim_engine #(
        .CTX(0), .W_ID(6), .HOLDOFF(3), .W_CNT(2)
    ) dut2 (
        .CLK(CLK), .RST(RST), .bus(ifc2.master)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic        we;
        logic [29:0] off;
        logic [31:0] data;
    } bus_t;

    bus_t       bus_q[$];
    logic [5:0] idq[$];

    // PLIC model: pending bits, priorities, registered claim read data.
    logic [63:0] pending   = '0;
    logic        stale     = 1'b0;
    int          prio[64];
    logic [63:0] raise_mask  = '0;
    logic        raise_stale = 1'b0;
    int          raise_seq = 0;
    int          seen_seq  = 0;
    logic [31:0] rdata_r   = '0;

    assign ifc.i_rdata = rdata_r;
    assign ifc.i_eip   = (|pending) | stale;

    function automatic int best(input logic [63:0] p);
        int b  = 0;
        int bp = 0;
        for (int i = 1; i < 64; i++)
            if (p[i] && prio[i] > bp) begin
                b  = i;
                bp = prio[i];
            end
        return b;
    endfunction

    always @(posedge CLK) begin : plic_model
        logic [63:0] p;
        int b;
        p = pending;
        if (ifc.o_re) begin
            b = best(p);
            rdata_r <= {26'($urandom), 6'(b)};
            p[b] = 1'b0;
            stale <= 1'b0;
        end
        if (raise_seq != seen_seq) begin
            p = p | raise_mask;
            stale    <= raise_stale;
            seen_seq <= raise_seq;
        end
        pending <= p;
    end

    logic en2 = 1'b0;
    int   rd2 = 0;
    assign ifc2.i_enable     = en2;
    assign ifc2.i_eip        = 1'b1;
    assign ifc2.i_gnt        = 1'b1;
    assign ifc2.i_rdata      = 32'h0;
    assign ifc2.i_id_ready   = 1'b0;
    assign ifc2.i_cmpl_valid = 1'b0;
    assign ifc2.i_cmpl_id    = 6'd0;

    // Scoreboard: bus accesses and ID handshakes are compared on the edge.
    always @(posedge CLK) begin : monitor
        bus_t e;
        logic [5:0] ei;
        if (!RST && (ifc.o_re || ifc.o_we)) begin
            if (bus_q.size() == 0) begin
                chk("bus_unexpected", 32'(ifc.o_offset), 32'h0);
            end else begin
                e = bus_q.pop_front();
                chk("bus_we", 32'(ifc.o_we), 32'(e.we));
                chk("bus_re", 32'(ifc.o_re), 32'(!e.we));
                chk("bus_offset", 32'(ifc.o_offset), 32'(e.off));
                chk("bus_wdata", ifc.o_wdata, e.data);
            end
        end
        if (!RST && ifc.o_id_valid && ifc.i_id_ready) begin
            if (idq.size() == 0) begin
                chk("id_unexpected", 32'(ifc.o_id), 32'h0);
            end else begin
                ei = idq.pop_front();
                chk("id_value", 32'(ifc.o_id), 32'(ei));
            end
        end
        if (ifc2.o_re) rd2 <= rd2 + 1;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic raise(input logic [63:0] m, input logic st);
        raise_mask  = m;
        raise_stale = st;
        raise_seq++;
    endtask

    task automatic expect_irq(input logic [5:0] id, input bit wr);
        bus_q.push_back('{we: 1'b0, off: 30'h200004, data: 32'h0});
        if (id != 0) idq.push_back(id);
        if (wr) bus_q.push_back('{we: 1'b1, off: 30'h200004,
                                  data: 32'(id)});
    endtask

    task automatic wait_id_valid();
        int n = 0;
        while (!ifc.o_id_valid && n < 50) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (!ifc.o_id_valid) chk("id_valid_timeout", 32'h0, 32'h1);
    endtask

    task automatic take_id();
        wait_id_valid();
        ifc.i_id_ready = 1'b1;
        @(posedge CLK);
        #1;
        ifc.i_id_ready = 1'b0;
    endtask

    task automatic give_cmpl(input logic [5:0] cid);
        int   n  = 0;
        logic hs = 1'b0;
        ifc.i_cmpl_valid = 1'b1;
        ifc.i_cmpl_id    = cid;
        while (!hs && n < 50) begin
            @(posedge CLK);
            hs = ifc.o_cmpl_ready;
            n++;
        end
        #1;
        ifc.i_cmpl_valid = 1'b0;
        if (!hs) chk("cmpl_timeout", 32'h0, 32'h1);
        else     chk("cmpl_to_we", 32'(ifc.o_we), 32'(ifc.i_gnt));
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_req"}, 32'(ifc.o_req), 32'h0);
        chk({tag, "_re"}, 32'(ifc.o_re), 32'h0);
        chk({tag, "_we"}, 32'(ifc.o_we), 32'h0);
        chk({tag, "_offset"}, 32'(ifc.o_offset), 32'h0);
        chk({tag, "_wdata"}, ifc.o_wdata, 32'h0);
        chk({tag, "_id_valid"}, 32'(ifc.o_id_valid), 32'h0);
        chk({tag, "_id"}, 32'(ifc.o_id), 32'h0);
        chk({tag, "_cmpl_ready"}, 32'(ifc.o_cmpl_ready), 32'h0);
        chk({tag, "_busy"}, 32'(ifc.o_busy), 32'h0);
        chk({tag, "_spur"}, 32'(ifc.o_spurious_cnt), 32'h0);
        chk({tag, "_err"}, 32'(ifc.o_cmpl_err), 32'h0);
    endtask

    initial begin : stim
        int   n;
        logic seen;
        for (int i = 0; i < 64; i++) prio[i] = 0;
        ifc.i_enable     = 1'b1;
        ifc.i_gnt        = 1'b1;
        ifc.i_id_ready   = 1'b0;
        ifc.i_cmpl_valid = 1'b0;
        ifc.i_cmpl_id    = 6'd0;

        // Reset state
        cycles(3);
        check_idle_outputs("reset");
        RST = 1'b0;
        cycles(2);

        // Single source 5, permanent grant, latency and same-cycle handshakes
        prio[5] = 1;
        expect_irq(6'd5, 1'b1);
        raise(64'd1 << 5, 1'b0);
        n = 0;
        while (!ifc.i_eip && n < 10) begin
            @(posedge CLK);
            #1;
            n++;
        end
        n = 0;
        while (!ifc.o_id_valid && n < 20) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("claim_latency", 32'(n), 32'd3);
        chk("first_id", 32'(ifc.o_id), 32'd5);
        ifc.i_id_ready   = 1'b1;
        ifc.i_cmpl_valid = 1'b1;
        ifc.i_cmpl_id    = 6'd5;
        @(posedge CLK);
        #1;
        ifc.i_id_ready = 1'b0;
        chk("same_cycle_cmpl_ignored", 32'(ifc.o_cmpl_ready), 32'h1);
        chk("no_early_we", 32'(ifc.o_we), 32'h0);
        @(posedge CLK);
        #1;
        ifc.i_cmpl_valid = 1'b0;
        chk("cmpl_to_we_t1", 32'(ifc.o_we), 32'h1);
        cycles(12);
        chk("t1_idle", 32'(ifc.o_busy), 32'h0);
        chk("t1_err", 32'(ifc.o_cmpl_err), 32'h0);
        chk("t1_sb_empty", 32'(bus_q.size()), 32'h0);

        // Priority order 7 then 3, re-claim only after holdoff
        prio[3] = 2;
        prio[7] = 4;
        expect_irq(6'd7, 1'b1);
        expect_irq(6'd3, 1'b1);
        raise((64'd1 << 3) | (64'd1 << 7), 1'b0);
        take_id();
        give_cmpl(6'd7);
        n = 0;
        while (!ifc.o_re && n < 20) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("holdoff_gap", 32'(n), 32'd5);
        take_id();
        give_cmpl(6'd3);
        cycles(12);
        chk("t2_sb_empty", 32'(bus_q.size() + idq.size()), 32'h0);
        chk("t2_idle", 32'(ifc.o_busy), 32'h0);

        // Stale EIP: claim returns 0
        chk("spur_before", 32'(ifc.o_spurious_cnt), 32'd0);
        expect_irq(6'd0, 1'b0);
        raise(64'd0, 1'b1);
        n = 0;
        while (!ifc.o_re && n < 20) begin
            @(posedge CLK);
            #1;
            n++;
        end
        n    = 0;
        seen = 1'b0;
        while (ifc.o_busy && n < 20) begin
            @(posedge CLK);
            #1;
            seen = seen | ifc.o_id_valid;
            n++;
        end
        chk("spur_to_idle", 32'(n), 32'd5);
        chk("spur_no_id_valid", 32'(seen), 32'h0);
        chk("spur_after", 32'(ifc.o_spurious_cnt), 32'd1);
        cycles(5);
        chk("spur_no_reclaim", 32'(ifc.o_busy), 32'h0);

        // Saturating 2-bit spurious counter
        en2 = 1'b1;
        n = 0;
        while (rd2 < 4 && n < 100) begin
            @(posedge CLK);
            #1;
            n++;
        end
        en2 = 1'b0;
        cycles(10);
        chk("sat_reads", 32'(rd2), 32'd4);
        chk("sat_cnt", 32'(ifc2.o_spurious_cnt), 32'd3);

        // Grant withheld in CLAIM_REQ and CMPL_REQ
        prio[2] = 1;
        expect_irq(6'd2, 1'b1);
        ifc.i_gnt = 1'b0;
        raise(64'd1 << 2, 1'b0);
        n = 0;
        while (!ifc.o_req && n < 20) begin
            @(posedge CLK);
            #1;
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("nogr_rd_req", 32'(ifc.o_req), 32'h1);
            chk("nogr_rd_re", 32'(ifc.o_re), 32'h0);
            chk("nogr_rd_off", 32'(ifc.o_offset), 32'h0);
            @(posedge CLK);
            #1;
        end
        ifc.i_gnt = 1'b1;
        #1;
        chk("gr_rd_re", 32'(ifc.o_re), 32'h1);
        chk("gr_rd_off", 32'(ifc.o_offset), 32'h200004);
        @(posedge CLK);
        #1;
        ifc.i_gnt = 1'b0;
        chk("gr_rd_req_drop", 32'(ifc.o_req), 32'h0);
        take_id();
        give_cmpl(6'd2);
        for (int i = 0; i < 10; i++) begin
            chk("nogr_wr_req", 32'(ifc.o_req), 32'h1);
            chk("nogr_wr_we", 32'(ifc.o_we), 32'h0);
            chk("nogr_wr_off", 32'(ifc.o_offset), 32'h0);
            chk("nogr_wr_wdata", ifc.o_wdata, 32'h0);
            @(posedge CLK);
            #1;
        end
        ifc.i_gnt = 1'b1;
        #1;
        chk("gr_wr_we", 32'(ifc.o_we), 32'h1);
        chk("gr_wr_wdata", ifc.o_wdata, 32'd2);
        @(posedge CLK);
        #1;
        chk("gr_wr_req_drop", 32'(ifc.o_req), 32'h0);
        cycles(8);

        // Early completion ignored; mismatched completion ID
        prio[9] = 1;
        expect_irq(6'd9, 1'b1);
        ifc.i_cmpl_valid = 1'b1;
        ifc.i_cmpl_id    = 6'd4;
        raise(64'd1 << 9, 1'b0);
        wait_id_valid();
        cycles(3);
        chk("early_cmpl_id_valid", 32'(ifc.o_id_valid), 32'h1);
        chk("early_cmpl_ready", 32'(ifc.o_cmpl_ready), 32'h0);
        chk("early_cmpl_id", 32'(ifc.o_id), 32'd9);
        chk("early_cmpl_err", 32'(ifc.o_cmpl_err), 32'h0);
        ifc.i_id_ready = 1'b1;
        @(posedge CLK);
        #1;
        ifc.i_id_ready = 1'b0;
        @(posedge CLK);
        #1;
        ifc.i_cmpl_valid = 1'b0;
        chk("mism_we", 32'(ifc.o_we), 32'h1);
        chk("mism_err", 32'(ifc.o_cmpl_err), 32'h1);
        cycles(10);
        chk("err_sticky", 32'(ifc.o_cmpl_err), 32'h1);

        // Reset while waiting for completion
        prio[11] = 1;
        expect_irq(6'd11, 1'b0);
        raise(64'd1 << 11, 1'b0);
        take_id();
        chk("pre_rst_cmpl_ready", 32'(ifc.o_cmpl_ready), 32'h1);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check_idle_outputs("midrst");
        RST = 1'b0;
        cycles(10);
        chk("midrst_idle", 32'(ifc.o_busy), 32'h0);
        chk("final_sb_empty", 32'(bus_q.size() + idq.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
